colour_bbox: RTL and testbench
==============================

COLOUR_BBOX -- requirements
Module: colour_bbox

Interface
REQ-001 Parameter IMAGE_W, default 640: pixels per line.
REQ-002 Parameter IMAGE_H, default 480: lines per frame.
REQ-003 Parameters R_MIN=160, G_MAX=80, B_MAX=80: target-colour thresholds, inclusive, 8-bit.
REQ-004 Parameter MIN_PIXELS, default 16: minimum masked-pixel count for a valid detection.
REQ-005 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset_n, input, 1: synchronous, active-low reset.
REQ-007 Ports in_valid, in_sop, in_eop, input, 1 each: pixel qualifier, first pixel of frame, last pixel of frame.
REQ-008 Ports red, green, blue, input, 8 each: blurred pixel from the upstream blur stage.
REQ-009 Ports out_valid, output, 1, and red_out, green_out, blue_out, output, 8 each: video pass-through.
REQ-010 Ports bbox_x_min, bbox_x_max, output, 11 each, and bbox_y_min, bbox_y_max, output, 10 each: detected box.
REQ-011 Ports bbox_found, bbox_valid, bbox_dropped, output, 1 each, and bbox_ready, input, 1: result handshake.
REQ-012 Port bbox_count, output, 19: masked pixels in the reported frame, saturating.

Function
REQ-013 A pixel SHALL be accepted only on a cycle with in_valid=1; all other inputs are ignored when in_valid=0.
REQ-014 FSM states: IDLE (wait for sop) and ACCUM; reset SHALL enter IDLE.
REQ-015 Accepted pixel with in_sop=1 SHALL set x=0, y=0, clear accumulators, and enter ACCUM from either state, discarding any partial frame.
REQ-016 In IDLE, accepted pixels without in_sop SHALL be ignored for detection.
REQ-017 After each accepted pixel, x SHALL increment; at x=IMAGE_W-1 it SHALL wrap to 0 and y SHALL increment, saturating at IMAGE_H-1.
REQ-018 mask = (red>=R_MIN) && (green<=G_MAX) && (blue<=B_MAX).
REQ-019 A masked pixel SHALL update min/max x/y and increment the count, which saturates at 2^19-1.
REQ-020 An accepted pixel with in_eop=1 SHALL include its own contribution, latch results into the bbox_* registers on the next edge, assert bbox_valid, and return to IDLE.
REQ-021 If in_sop and in_eop are both set on one accepted pixel, the result SHALL be a one-pixel frame.
REQ-022 bbox_found = (count >= MIN_PIXELS); when 0, all four coordinates SHALL report 0.
REQ-023 bbox_valid SHALL hold with stable outputs until a cycle with bbox_valid && bbox_ready, then clear on the next edge.
REQ-024 If a new result latches while bbox_valid=1 and bbox_ready=0, the new result SHALL overwrite, bbox_valid SHALL stay 1, and bbox_dropped SHALL pulse high for one cycle.
REQ-025 If a new result latches in the same cycle as a handshake, the new result SHALL be presented and bbox_valid SHALL stay 1, with no drop.
REQ-026 Video pass-through latency SHALL be exactly 1 cycle, and out_valid SHALL be in_valid delayed by 1.

Reset
REQ-027 With reset_n=0 at a clock edge, the following SHALL be 0 on the next edge: all outputs, x, y, accumulators and the stored overlay box; the state SHALL be IDLE.
REQ-028 Reset mid-frame SHALL discard the frame, and no result SHALL be produced for it.

Configuration
REQ-029 Macro COLOUR_BBOX_OVERLAY_EN defined: output pixels lying on the edge of the last latched found box SHALL be forced to (255,0,0), where the edge is x equal to min or max with y in range, or y equal to min or max with x in range.
REQ-030 Macro COLOUR_BBOX_OVERLAY_EN undefined: the output pixel SHALL equal the input pixel delayed by 1 cycle, and no overlay storage SHALL exist.
REQ-031 Macro COLOUR_BBOX_OVERLAY_EN defined: no overlay SHALL be drawn until the first found box after reset.

Verification
REQ-032 Bench SHALL use IMAGE_W=8, IMAGE_H=4, MIN_PIXELS=2, bbox_ready=1 unless stated.
REQ-033 Frame with (200,10,10) at (2,1),(5,1),(3,2), other pixels black -> bbox 2..5 x 1..2, count 3, found=1, bbox_valid for 1 cycle.
REQ-034 Frame with a single masked pixel at (7,3) -> count 1, found=0, coordinates 0.
REQ-035 bbox_ready=0 across two frames -> second result shown, bbox_dropped pulses once, bbox_valid held.
REQ-036 sop reasserted at pixel 10 of a frame that has masks before it -> earlier masks excluded; reset_n=0 mid-frame -> no bbox_valid for that frame.
REQ-037 Overlay build, frame 2 after the REQ-033 box -> pixel (2,1) output as (255,0,0) and pixel (0,0) passed unchanged, 1-cycle latency.

Source files
------------

// File: rtl/colour_bbox.sv
// colour_bbox: single-colour blob detector with a bounding-box result handshake.
//
// Pixels arrive in raster order, qualified by in_valid and framed by in_sop/in_eop.
// Each pixel is thresholded against a target colour. The min/max coordinates and the
// count of matching pixels are accumulated over the frame. On the end-of-frame pixel
// the result is latched into the bbox_* registers, and bbox_valid is raised until it
// is taken with bbox_ready. The video stream passes through with one cycle of latency.
//
// Ports
//   clk, reset_n                      clock, synchronous active-low reset
//   in_valid, in_sop, in_eop          pixel qualifier, first / last pixel of frame
//   red, green, blue                  input pixel
//   out_valid, red_out..blue_out      pixel pass-through, 1-cycle latency
//   bbox_x_min/max, bbox_y_min/max    detected box (all zero when nothing found)
//   bbox_found, bbox_count            detection flag, masked-pixel count (saturating)
//   bbox_valid, bbox_ready            result handshake
//   bbox_dropped                      1-cycle pulse when an untaken result is overwritten
//
// Build option
//   COLOUR_BBOX_OVERLAY_EN            when defined, draws the edge of the last found box
//                                     in pure red on the output video.
module colour_bbox #(
  parameter int unsigned IMAGE_W    = 640,
  parameter int unsigned IMAGE_H    = 480,
  parameter int unsigned R_MIN      = 160,
  parameter int unsigned G_MAX      = 80,
  parameter int unsigned B_MAX      = 80,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        out_valid,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic [10:0] bbox_x_min,
  output logic [10:0] bbox_x_max,
  output logic [9:0]  bbox_y_min,
  output logic [9:0]  bbox_y_max,
  output logic        bbox_found,
  output logic        bbox_valid,
  output logic        bbox_dropped,
  input  logic        bbox_ready,
  output logic [18:0] bbox_count
);

  localparam logic [10:0] XLast  = 11'(IMAGE_W - 1);
  localparam logic [9:0]  YLast  = 10'(IMAGE_H - 1);
  localparam logic [18:0] CntMax = '1;
  localparam logic [18:0] MinCnt = 19'(MIN_PIXELS);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [9:0]  acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [18:0] acc_cnt_q, acc_cnt_d;

  logic [10:0] res_x_min_q, res_x_min_d, res_x_max_q, res_x_max_d;
  logic [9:0]  res_y_min_q, res_y_min_d, res_y_max_q, res_y_max_d;
  logic [18:0] res_cnt_q, res_cnt_d;
  logic        res_found_q, res_found_d;
  logic        res_valid_q, res_valid_d;
  logic        res_drop_q, res_drop_d;

  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

  // Per-pixel view of the frame, with a start-of-frame pixel seeing empty accumulators.
  logic        frame_px, mask, new_res, found;
  logic [10:0] cur_x, base_x_min, base_x_max, fin_x_min, fin_x_max;
  logic [9:0]  cur_y, base_y_min, base_y_max, fin_y_min, fin_y_max;
  logic [18:0] base_cnt, fin_cnt;

  always_comb begin
    frame_px   = in_valid && (in_sop || (state_q == StAccum));
    mask       = (red >= 8'(R_MIN)) && (green <= 8'(G_MAX)) && (blue <= 8'(B_MAX));
    cur_x      = in_sop ? '0 : x_q;
    cur_y      = in_sop ? '0 : y_q;
    base_cnt   = in_sop ? '0 : acc_cnt_q;
    base_x_min = in_sop ? '0 : acc_x_min_q;
    base_x_max = in_sop ? '0 : acc_x_max_q;
    base_y_min = in_sop ? '0 : acc_y_min_q;
    base_y_max = in_sop ? '0 : acc_y_max_q;

    fin_cnt   = base_cnt;
    fin_x_min = base_x_min;
    fin_x_max = base_x_max;
    fin_y_min = base_y_min;
    fin_y_max = base_y_max;
    if (mask) begin
      // An empty accumulator holds no meaningful box, so the first hit seeds it.
      if (base_cnt == '0) begin
        fin_x_min = cur_x;
        fin_x_max = cur_x;
        fin_y_min = cur_y;
        fin_y_max = cur_y;
      end else begin
        if (cur_x < base_x_min) fin_x_min = cur_x;
        if (cur_x > base_x_max) fin_x_max = cur_x;
        if (cur_y < base_y_min) fin_y_min = cur_y;
        if (cur_y > base_y_max) fin_y_max = cur_y;
      end
      fin_cnt = (base_cnt == CntMax) ? base_cnt : base_cnt + 19'd1;
    end

    new_res = frame_px && in_eop;
    found   = (fin_cnt >= MinCnt);
  end

  // Frame position and accumulator next state.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    acc_cnt_d   = acc_cnt_q;
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;
    if (frame_px) begin
      acc_cnt_d   = fin_cnt;
      acc_x_min_d = fin_x_min;
      acc_x_max_d = fin_x_max;
      acc_y_min_d = fin_y_min;
      acc_y_max_d = fin_y_max;
      if (cur_x == XLast) begin
        x_d = '0;
        y_d = (cur_y == YLast) ? cur_y : cur_y + 10'd1;
      end else begin
        x_d = cur_x + 11'd1;
        y_d = cur_y;
      end
      state_d = in_eop ? StIdle : StAccum;
    end
  end

  // Result registers and handshake.
  always_comb begin
    res_x_min_d = res_x_min_q;
    res_x_max_d = res_x_max_q;
    res_y_min_d = res_y_min_q;
    res_y_max_d = res_y_max_q;
    res_cnt_d   = res_cnt_q;
    res_found_d = res_found_q;
    if (new_res) begin
      res_x_min_d = found ? fin_x_min : '0;
      res_x_max_d = found ? fin_x_max : '0;
      res_y_min_d = found ? fin_y_min : '0;
      res_y_max_d = found ? fin_y_max : '0;
      res_cnt_d   = fin_cnt;
      res_found_d = found;
    end
    // A result arriving with a handshake simply replaces the one being taken.
    res_valid_d = new_res || (res_valid_q && !bbox_ready);
    res_drop_d  = new_res && res_valid_q && !bbox_ready;
  end

  // Video pass-through, optionally with the box overlay.
  always_comb begin
    out_valid_d = in_valid;
  end

`ifdef COLOUR_BBOX_OVERLAY_EN
  logic        ov_have_q, ov_have_d;
  logic [10:0] ov_x_min_q, ov_x_min_d, ov_x_max_q, ov_x_max_d;
  logic [9:0]  ov_y_min_q, ov_y_min_d, ov_y_max_q, ov_y_max_d;
  logic        ov_x_in, ov_y_in, ov_hit;

  always_comb begin
    ov_have_d  = ov_have_q;
    ov_x_min_d = ov_x_min_q;
    ov_x_max_d = ov_x_max_q;
    ov_y_min_d = ov_y_min_q;
    ov_y_max_d = ov_y_max_q;
    if (new_res && found) begin
      ov_have_d  = 1'b1;
      ov_x_min_d = fin_x_min;
      ov_x_max_d = fin_x_max;
      ov_y_min_d = fin_y_min;
      ov_y_max_d = fin_y_max;
    end

    // The box in use is the one latched before this pixel, never the frame in flight.
    ov_x_in = (cur_x >= ov_x_min_q) && (cur_x <= ov_x_max_q);
    ov_y_in = (cur_y >= ov_y_min_q) && (cur_y <= ov_y_max_q);
    ov_hit  = ov_have_q && frame_px &&
              ((((cur_x == ov_x_min_q) || (cur_x == ov_x_max_q)) && ov_y_in) ||
               (((cur_y == ov_y_min_q) || (cur_y == ov_y_max_q)) && ov_x_in));
    out_r_d = ov_hit ? 8'hFF : red;
    out_g_d = ov_hit ? 8'h00 : green;
    out_b_d = ov_hit ? 8'h00 : blue;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ov_have_q  <= 1'b0;
      ov_x_min_q <= '0;
      ov_x_max_q <= '0;
      ov_y_min_q <= '0;
      ov_y_max_q <= '0;
    end else begin
      ov_have_q  <= ov_have_d;
      ov_x_min_q <= ov_x_min_d;
      ov_x_max_q <= ov_x_max_d;
      ov_y_min_q <= ov_y_min_d;
      ov_y_max_q <= ov_y_max_d;
    end
  end
`else
  always_comb begin
    out_r_d = red;
    out_g_d = green;
    out_b_d = blue;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      acc_cnt_q   <= '0;
      acc_x_min_q <= '0;
      acc_x_max_q <= '0;
      acc_y_min_q <= '0;
      acc_y_max_q <= '0;
      res_x_min_q <= '0;
      res_x_max_q <= '0;
      res_y_min_q <= '0;
      res_y_max_q <= '0;
      res_cnt_q   <= '0;
      res_found_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_drop_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      res_x_min_q <= res_x_min_d;
      res_x_max_q <= res_x_max_d;
      res_y_min_q <= res_y_min_d;
      res_y_max_q <= res_y_max_d;
      res_cnt_q   <= res_cnt_d;
      res_found_q <= res_found_d;
      res_valid_q <= res_valid_d;
      res_drop_q  <= res_drop_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign red_out      = out_r_q;
  assign green_out    = out_g_q;
  assign blue_out     = out_b_q;
  assign bbox_x_min   = res_x_min_q;
  assign bbox_x_max   = res_x_max_q;
  assign bbox_y_min   = res_y_min_q;
  assign bbox_y_max   = res_y_max_q;
  assign bbox_count   = res_cnt_q;
  assign bbox_found   = res_found_q;
  assign bbox_valid   = res_valid_q;
  assign bbox_dropped = res_drop_q;

endmodule

// File: tb/tb_colour_bbox.sv
// Randomised bench for colour_bbox against a frame-level reference model: the model
// keeps a list of masked pixel coordinates per frame and derives the box from it at
// end of frame.
module tb_colour_bbox;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int MINP = 2;
  localparam int NPX  = W * H;
`ifdef COLOUR_BBOX_OVERLAY_EN
  localparam bit OvEn = 1'b1;
`else
  localparam bit OvEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        out_valid;
  logic [7:0]  red_out, green_out, blue_out;
  logic [10:0] bbox_x_min, bbox_x_max;
  logic [9:0]  bbox_y_min, bbox_y_max;
  logic        bbox_found, bbox_valid, bbox_dropped;
  logic        bbox_ready = 1'b1;
  logic [18:0] bbox_count;

  always #5 clk = ~clk;

  colour_bbox #(
    .IMAGE_W(W), .IMAGE_H(H), .R_MIN(160), .G_MAX(80), .B_MAX(80), .MIN_PIXELS(MINP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
    .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
    .bbox_found(bbox_found), .bbox_valid(bbox_valid), .bbox_dropped(bbox_dropped),
    .bbox_ready(bbox_ready), .bbox_count(bbox_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit   m_in_frame;
  int   m_idx;
  int   qx[$], qy[$];
  bit   m_valid, m_drop, m_found;
  int   m_cnt, m_x0, m_x1, m_y0, m_y1;
  bit   ov_have;
  int   ov_x0, ov_x1, ov_y0, ov_y1;
  bit   e_ov;
  logic [7:0] e_r, e_g, e_b;
  int   ready_mode;  // 0: held low, 1: held high, 2: random

  logic [7:0] fr_r [NPX], fr_g [NPX], fr_b [NPX];

  function automatic bit is_mask(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return (r >= 160) && (g <= 80) && (b <= 80);
  endfunction

  function automatic bit on_box_edge(input int cx, input int cy);
    return (((cx == ov_x0) || (cx == ov_x1)) && (cy >= ov_y0) && (cy <= ov_y1)) ||
           (((cy == ov_y0) || (cy == ov_y1)) && (cx >= ov_x0) && (cx <= ov_x1));
  endfunction

  task automatic model_reset();
    m_in_frame = 0; m_idx = 0; qx.delete(); qy.delete();
    m_valid = 0; m_drop = 0; m_found = 0;
    m_cnt = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
    ov_have = 0; ov_x0 = 0; ov_x1 = 0; ov_y0 = 0; ov_y1 = 0;
    e_ov = 0; e_r = '0; e_g = '0; e_b = '0;
  endtask

  task automatic model_step(input bit v, input bit sop, input bit eop,
                            input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input bit rdy);
    bit newres;
    int cx, cy;
    newres = 0;
    e_ov = v; e_r = r; e_g = g; e_b = b;
    if (v && (sop || m_in_frame)) begin
      if (sop) begin
        m_in_frame = 1; m_idx = 0; qx.delete(); qy.delete();
      end
      cx = m_idx % W;
      cy = m_idx / W;
      if (cy > H - 1) cy = H - 1;
      if (OvEn && ov_have && on_box_edge(cx, cy)) begin
        e_r = 8'hFF; e_g = 8'h00; e_b = 8'h00;
      end
      if (is_mask(r, g, b)) begin
        qx.push_back(cx); qy.push_back(cy);
      end
      m_idx++;
      if (eop) begin
        newres = 1; m_in_frame = 0;
      end
    end
    m_drop  = newres && m_valid && !rdy;
    m_valid = newres || (m_valid && !rdy);
    if (newres) begin
      m_cnt   = qx.size();
      m_found = (m_cnt >= MINP);
      m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
      if (m_found) begin
        m_x0 = W; m_x1 = -1; m_y0 = H; m_y1 = -1;
        foreach (qx[i]) begin
          if (qx[i] < m_x0) m_x0 = qx[i];
          if (qx[i] > m_x1) m_x1 = qx[i];
          if (qy[i] < m_y0) m_y0 = qy[i];
          if (qy[i] > m_y1) m_y1 = qy[i];
        end
        ov_have = 1; ov_x0 = m_x0; ov_x1 = m_x1; ov_y0 = m_y0; ov_y1 = m_y1;
      end
    end
  endtask

  task automatic compare_all();
    check("out_valid", out_valid, e_ov);
    check("pixel", {red_out, green_out, blue_out}, {e_r, e_g, e_b});
    check("bbox_valid", bbox_valid, m_valid);
    check("bbox_dropped", bbox_dropped, m_drop);
    if (m_valid) begin
      check("bbox_found", bbox_found, m_found);
      check("bbox_count", bbox_count, m_cnt);
      check("bbox_x_min", bbox_x_min, m_x0);
      check("bbox_x_max", bbox_x_max, m_x1);
      check("bbox_y_min", bbox_y_min, m_y0);
      check("bbox_y_max", bbox_y_max, m_y1);
    end
  endtask

  task automatic drive(input bit v, input bit sop, input bit eop,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bit rdy;
    rdy = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    in_valid = v; in_sop = sop; in_eop = eop;
    red = r; green = g; blue = b; bbox_ready = rdy;
    model_step(v, sop, eop, r, g, b, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'($urandom_range(0, 1)); in_sop = 1'b0; in_eop = 1'b1;
    red = 8'd200; green = 8'd0; blue = 8'd0;
    @(posedge clk);
    #1;
    model_reset();
    check("rst out_valid", out_valid, 0);
    check("rst pixel", {red_out, green_out, blue_out}, 0);
    check("rst bbox_valid", bbox_valid, 0);
    check("rst bbox_dropped", bbox_dropped, 0);
    check("rst bbox_found", bbox_found, 0);
    check("rst bbox_count", bbox_count, 0);
    check("rst bbox_x", {bbox_x_min, bbox_x_max}, 0);
    check("rst bbox_y", {bbox_y_min, bbox_y_max}, 0);
    reset_n = 1'b1;
  endtask

  task automatic clear_frame();
    for (int i = 0; i < NPX; i++) begin
      fr_r[i] = '0; fr_g[i] = '0; fr_b[i] = '0;
    end
  endtask

  task automatic set_px(input int x, input int y,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    fr_r[y * W + x] = r; fr_g[y * W + x] = g; fr_b[y * W + x] = b;
  endtask

  // Colours clustered around the thresholds so both sides of each compare get exercised.
  task automatic rand_frame();
    for (int i = 0; i < NPX; i++) begin
      case ($urandom_range(0, 4))
        0: fr_r[i] = 8'd159;
        1: fr_r[i] = 8'd160;
        2: fr_r[i] = 8'd255;
        default: fr_r[i] = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: fr_g[i] = 8'd80;
        1: fr_g[i] = 8'd81;
        2: fr_g[i] = 8'd0;
        default: fr_g[i] = 8'($urandom_range(0, 120));
      endcase
      case ($urandom_range(0, 3))
        0: fr_b[i] = 8'd80;
        1: fr_b[i] = 8'd81;
        2: fr_b[i] = 8'd0;
        default: fr_b[i] = 8'($urandom_range(0, 120));
      endcase
    end
  endtask

  task automatic send_frame(input int sop2_at, input bit gaps, input int stop_at);
    for (int i = 0; i < NPX && i != stop_at; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      drive(1, (i == 0) || (i == sop2_at), i == NPX - 1, fr_r[i], fr_g[i], fr_b[i]);
    end
  endtask

  initial begin
    model_reset();
    ready_mode = 1;
    do_reset();
    idle(3);

    // Three-pixel box spanning x 2..5, y 1..2.
    clear_frame();
    set_px(2, 1, 8'd200, 8'd10, 8'd10);
    set_px(5, 1, 8'd200, 8'd10, 8'd10);
    set_px(3, 2, 8'd200, 8'd10, 8'd10);
    send_frame(-1, 0, -1);
    idle(3);

    // Single masked pixel in the last position: below MIN_PIXELS.
    clear_frame();
    set_px(7, 3, 8'd200, 8'd10, 8'd10);
    send_frame(-1, 0, -1);
    idle(3);

    // One-pixel frame (sop and eop together).
    drive(1, 1, 1, 8'd160, 8'd80, 8'd80);
    idle(2);

    // Consumer stalled across two frames: second overwrites with a drop pulse.
    ready_mode = 0;
    rand_frame();
    send_frame(-1, 0, -1);
    idle(2);
    rand_frame();
    send_frame(-1, 0, -1);
    idle(3);
    ready_mode = 1;
    idle(3);

    // Restart at pixel 10: masks before it must not count.
    clear_frame();
    set_px(1, 0, 8'd250, 8'd0, 8'd0);
    set_px(0, 1, 8'd250, 8'd0, 8'd0);
    set_px(4, 2, 8'd250, 8'd0, 8'd0);
    set_px(6, 3, 8'd250, 8'd0, 8'd0);
    send_frame(10, 0, -1);
    idle(3);

    // Reset mid-frame: the partial frame yields no result.
    rand_frame();
    send_frame(-1, 0, 10);
    do_reset();
    idle(5);

    // Randomised frames with gaps, stray out-of-frame pixels and random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        drive(1, 0, 1'($urandom_range(0, 1)), 8'd255, 8'd0, 8'd0);
      rand_frame();
      send_frame(($urandom_range(0, 4) == 0) ? int'($urandom_range(1, NPX - 1)) : -1, 1, -1);
      idle($urandom_range(0, 4));
    end
    ready_mode = 1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
